multi_db_counter: RTL and testbench

MULTI_DB_COUNTER -- requirements
Module: multi_db_counter

---
 rtl/multi_db_counter_if.sv | 25 ++
 rtl/multi_db_counter.sv | 124 ++++++++++++
 tb/tb_multi_db_counter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/multi_db_counter_if.sv
// rtl/multi_db_counter_if.sv - button inputs, controls and debounce/counter outputs of multi_db_counter
interface multi_db_counter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       btn;
  logic [N_CH-1:0]       clr;
  logic [1:0]            mode;
  logic                  sat;
  logic [N_CH-1:0]       db_level;
  logic [N_CH-1:0]       db_tick;
  logic [N_CH*CNT_W-1:0] raw_cnt;
  logic [N_CH*CNT_W-1:0] db_cnt;
  logic [N_CH-1:0]       ovf;

  modport master (
    output btn, clr, mode, sat,
    input  db_level, db_tick, raw_cnt, db_cnt, ovf
  );

  modport slave (
    input  btn, clr, mode, sat,
    output db_level, db_tick, raw_cnt, db_cnt, ovf
  );
endinterface

// File: rtl/multi_db_counter.sv
// rtl/multi_db_counter.sv - per-channel button synchroniser, debouncer and raw/debounced edge counters
module multi_db_counter #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 2000000
) (
  input logic                clk,
  input logic                reset_n,
  multi_db_counter_if.slave  bus
);
  localparam int              TW   = $clog2(DB_CYCLES);
  localparam logic [TW-1:0]   TMAX = TW'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [N_CH-1:0]  sync1_q, sync1_d;
  logic [N_CH-1:0]  sync_q, sync_d;
  logic [N_CH-1:0]  sync_prev_q, sync_prev_d;
  logic [N_CH-1:0]  db_level_q, db_level_d;
  logic [N_CH-1:0]  db_tick_q, db_tick_d;
  logic [N_CH-1:0]  ovf_q, ovf_d;
  logic [N_CH-1:0]  raw_ev;
  logic [TW-1:0]    timer_q [N_CH];
  logic [TW-1:0]    timer_d [N_CH];
  logic [CNT_W-1:0] raw_cnt_q [N_CH];
  logic [CNT_W-1:0] raw_cnt_d [N_CH];
  logic [CNT_W-1:0] db_cnt_q [N_CH];
  logic [CNT_W-1:0] db_cnt_d [N_CH];

  // Mode 11 falls back to rising-edge behaviour.
  function automatic logic edge_ok(input logic [1:0] m, input logic new_lvl);
    case (m)
      2'b01:   edge_ok = !new_lvl;
      2'b10:   edge_ok = 1'b1;
      default: edge_ok = new_lvl;
    endcase
  endfunction

  always_comb begin
    sync1_d     = bus.btn;
    sync_d      = sync1_q;
    sync_prev_d = sync_q;
    db_level_d  = db_level_q;
    db_tick_d   = '0;
    ovf_d       = ovf_q;
    raw_ev      = '0;
    for (int i = 0; i < N_CH; i++) begin
      timer_d[i]   = '0;
      raw_cnt_d[i] = raw_cnt_q[i];
      db_cnt_d[i]  = db_cnt_q[i];

      // Any cycle agreeing with the accepted level restarts the window.
      if (sync_q[i] != db_level_q[i]) begin
        if (timer_q[i] == TMAX) begin
          db_level_d[i] = sync_q[i];
          db_tick_d[i]  = edge_ok(bus.mode, sync_q[i]);
        end else begin
          timer_d[i] = timer_q[i] + 1'b1;
        end
      end

      raw_ev[i] = (sync_q[i] != sync_prev_q[i]) && edge_ok(bus.mode, sync_q[i]);

      if (bus.clr[i]) begin
        raw_cnt_d[i] = '0;
        db_cnt_d[i]  = '0;
        ovf_d[i]     = 1'b0;
      end else begin
        if (raw_ev[i]) begin
          if (raw_cnt_q[i] == CMAX) begin
            ovf_d[i]     = 1'b1;
            raw_cnt_d[i] = bus.sat ? CMAX : '0;
          end else begin
            raw_cnt_d[i] = raw_cnt_q[i] + 1'b1;
          end
        end
        if (db_tick_q[i]) begin
          if (db_cnt_q[i] == CMAX) begin
            ovf_d[i]    = 1'b1;
            db_cnt_d[i] = bus.sat ? CMAX : '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
      db_level_q  <= '0;
      db_tick_q   <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < N_CH; i++) begin
        timer_q[i]   <= '0;
        raw_cnt_q[i] <= '0;
        db_cnt_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      db_level_q  <= db_level_d;
      db_tick_q   <= db_tick_d;
      ovf_q       <= ovf_d;
      for (int i = 0; i < N_CH; i++) begin
        timer_q[i]   <= timer_d[i];
        raw_cnt_q[i] <= raw_cnt_d[i];
        db_cnt_q[i]  <= db_cnt_d[i];
      end
    end
  end

  assign bus.db_level = db_level_q;
  assign bus.db_tick  = db_tick_q;
  assign bus.ovf      = ovf_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign bus.raw_cnt[g*CNT_W +: CNT_W] = raw_cnt_q[g];
    assign bus.db_cnt[g*CNT_W +: CNT_W]  = db_cnt_q[g];
  end
endmodule

// File: tb/tb_multi_db_counter.sv
// tb/tb_multi_db_counter.sv - directed bench with a db_tick scoreboard for multi_db_counter
module tb_multi_db_counter;
  localparam int N_CH  = 4;
  localparam int CNT_W = 4;
  localparam int DBC   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   tick_q[$];

  multi_db_counter_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

  multi_db_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .DB_CYCLES(DBC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [N_CH*CNT_W-1:0] v, input int ch);
    return 32'(v[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every db_tick bit must match the next channel the stimulus predicted.
  always @(negedge clk) begin
    if (reset_n && bus.db_tick != '0) begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.db_tick[c]) begin
          if (tick_q.size() == 0) begin
            chk("tick_unexpected", 32'(c), 32'hFFFF);
          end else begin
            chk("tick_channel", 32'(c), 32'(tick_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic press_release(input int ch, input bit exp_rise, input bit exp_fall);
    if (exp_rise) tick_q.push_back(ch);
    bus.btn[ch] = 1'b1;
    step(8);
    if (exp_fall) tick_q.push_back(ch);
    bus.btn[ch] = 1'b0;
    step(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn = '0; bus.clr = '0; bus.mode = 2'b00; bus.sat = 1'b0;
    step(2);
    chk("rst_level", 32'(bus.db_level), 0);
    chk("rst_cnt", 32'({bus.raw_cnt, bus.db_cnt}), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    reset_n = 1'b1;
    step(2);

    // clean press on ch0
    tick_q.push_back(0);
    bus.btn[0] = 1'b1;
    step(5);
    chk("clean_lvl_e5", 32'(bus.db_level[0]), 0);
    step(1);
    chk("clean_lvl_e6", 32'(bus.db_level[0]), 1);
    chk("clean_tick_e6", 32'(bus.db_tick), 32'h1);
    step(1);
    chk("clean_tick_e7", 32'(bus.db_tick), 0);
    chk("clean_dbcnt", fld(bus.db_cnt, 0), 1);
    chk("clean_rawcnt", fld(bus.raw_cnt, 0), 1);
    bus.btn[0] = 1'b0;
    step(8);

    // bounce on ch1
    bus.btn[1] = 1'b1; step(1);
    bus.btn[1] = 1'b0; step(1);
    bus.btn[1] = 1'b1; step(1);
    bus.btn[1] = 1'b0; step(1);
    tick_q.push_back(1);
    bus.btn[1] = 1'b1;
    step(5);
    chk("bounce_lvl_e5", 32'(bus.db_level[1]), 0);
    step(1);
    chk("bounce_lvl_e6", 32'(bus.db_level[1]), 1);
    step(2);
    chk("bounce_raw", fld(bus.raw_cnt, 1), 3);
    chk("bounce_db", fld(bus.db_cnt, 1), 1);
    bus.btn[1] = 1'b0;
    step(8);

    // mode both, then falling only on ch2
    bus.mode = 2'b10;
    press_release(2, 1'b1, 1'b1);
    chk("mode10_db", fld(bus.db_cnt, 2), 2);
    chk("mode10_raw", fld(bus.raw_cnt, 2), 2);
    bus.clr[2] = 1'b1; step(1); bus.clr[2] = 1'b0;
    chk("clr2_db", fld(bus.db_cnt, 2), 0);
    bus.mode = 2'b01;
    press_release(2, 1'b0, 1'b1);
    chk("mode01_db", fld(bus.db_cnt, 2), 1);
    chk("mode01_raw", fld(bus.raw_cnt, 2), 1);

    // saturation and wrap on ch0
    bus.mode = 2'b00;
    bus.sat = 1'b1;
    bus.clr[0] = 1'b1; step(1); bus.clr[0] = 1'b0;
    for (int k = 0; k < 15; k++) press_release(0, 1'b1, 1'b0);
    chk("sat15_db", fld(bus.db_cnt, 0), 15);
    chk("sat15_ovf", 32'(bus.ovf[0]), 0);
    press_release(0, 1'b1, 1'b0);
    chk("sat16_db", fld(bus.db_cnt, 0), 15);
    chk("sat16_raw", fld(bus.raw_cnt, 0), 15);
    chk("sat16_ovf", 32'(bus.ovf[0]), 1);
    bus.sat = 1'b0;
    bus.clr[0] = 1'b1; step(1); bus.clr[0] = 1'b0;
    chk("clr0_ovf", 32'(bus.ovf[0]), 0);
    for (int k = 0; k < 16; k++) press_release(0, 1'b1, 1'b0);
    chk("wrap_db", fld(bus.db_cnt, 0), 0);
    chk("wrap_raw", fld(bus.raw_cnt, 0), 0);
    chk("wrap_ovf", 32'(bus.ovf[0]), 1);
    chk("wrap_ovf_other", 32'(bus.ovf[3:1]), 0);

    // clr coincident with db_tick on ch3
    tick_q.push_back(3);
    bus.btn[3] = 1'b1;
    step(6);
    chk("clr_tick_seen", 32'(bus.db_tick[3]), 1);
    bus.clr[3] = 1'b1; step(1); bus.clr[3] = 1'b0;
    chk("clr_tick_db", fld(bus.db_cnt, 3), 0);
    chk("clr_tick_ovf", 32'(bus.ovf[3]), 0);
    step(3);
    chk("clr_tick_db_hold", fld(bus.db_cnt, 3), 0);

    // reset mid-debounce on ch0 (timer at 2), ch3 still held
    bus.btn[0] = 1'b1;
    step(4);
    reset_n = 1'b0;
    #1;
    chk("arst_level", 32'(bus.db_level), 0);
    chk("arst_cnt", 32'({bus.raw_cnt, bus.db_cnt}), 0);
    chk("arst_ovf", 32'(bus.ovf), 0);
    step(2);
    reset_n = 1'b1;
    tick_q.push_back(0);
    tick_q.push_back(3);
    step(1);
    chk("post_rst_tick_e1", 32'(bus.db_tick), 0);
    step(4);
    chk("post_rst_lvl_e5", 32'(bus.db_level), 0);
    step(1);
    chk("post_rst_lvl_e6", 32'(bus.db_level), 32'h9);
    step(2);
    chk("post_rst_db0", fld(bus.db_cnt, 0), 1);
    chk("post_rst_db3", fld(bus.db_cnt, 3), 1);
    chk("post_rst_raw0", fld(bus.raw_cnt, 0), 1);
    chk("tick_queue_empty", 32'(tick_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
